// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional macro MULDIV_ZERO_SHORTCUT_EN: divide by zero completes in one busy cycle.
module mul_div_unit #(
    parameter int unsigned MUL_LATENCY = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        write_hi,
    input  logic        write_lo,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;      // multiplicand, or dividend shifting into quotient
    logic [31:0] b_q, b_d;      // multiplier, or divisor magnitude
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        skip_q, skip_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [63:0] prod_s, prod_u, prod;
    logic [31:0] a_abs, b_abs;
    logic [32:0] shifted;
    logic [31:0] rem_sub, rem_next;
    logic        ge;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign prod   = sgn_q ? prod_s : prod_u;

    assign a_abs = (op == 2'd2 && A[31]) ? -A : A;
    assign b_abs = (op == 2'd2 && B[31]) ? -B : B;

    // One restoring step: shift next dividend bit into the partial remainder.
    assign shifted  = {rem_q, a_q[31]};
    assign ge       = shifted >= {1'b0, b_q};
    assign rem_sub  = shifted[31:0] - b_q;
    assign rem_next = ge ? rem_sub : shifted[31:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        skip_d  = skip_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (!cancel) begin
                        if (!op[1]) begin
                            state_d = StMul;
                            cnt_d   = 5'(MUL_LATENCY - 1);
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (op == 2'd0);
                        end else begin
                            state_d = StDiv;
                            cnt_d   = 5'd31;
                            a_d     = a_abs;
                            b_d     = b_abs;
                            rem_d   = 32'd0;
                            q_neg_d = (op == 2'd2) && (A[31] ^ B[31]);
                            r_neg_d = (op == 2'd2) && A[31];
                            skip_d  = 1'b0;
`ifdef MULDIV_ZERO_SHORTCUT_EN
                            if (B == 32'd0) begin
                                state_d = StFix;
                                skip_d  = 1'b1;
                            end
`endif
                        end
                    end
                end else begin
                    if (write_hi) hi_d = A;
                    if (write_lo) lo_d = A;
                end
            end
            StMul: begin
                if (cancel) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    state_d = StIdle;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDiv: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_next;
                    a_d   = {a_q[30:0], ge};
                    if (cnt_q == 5'd0) state_d = StFix;
                    else cnt_d = cnt_q - 5'd1;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!skip_q) begin
                        lo_d = q_neg_q ? -a_q : a_q;
                        hi_d = r_neg_q ? -rem_q : rem_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            skip_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            skip_q  <= skip_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
